// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole session controller: state encodings
// and the score-to-difficulty tier table.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ARM   = 3'd2,
      ST_PLAY  = 3'd3,
      ST_END   = 3'd4
   } state_e;

   localparam logic [31:0] TIER_LIM0 = 32'd5;
   localparam logic [31:0] TIER_LIM1 = 32'd10;
   localparam logic [31:0] TIER_LIM2 = 32'd20;

   localparam logic [2:0]  NUM_LIT_T0 = 3'd1;
   localparam logic [2:0]  NUM_LIT_T1 = 3'd2;
   localparam logic [2:0]  NUM_LIT_T2 = 3'd3;
   localparam logic [2:0]  NUM_LIT_T3 = 3'd4;

   localparam logic [15:0] PRESET_T0 = 16'd5000;
   localparam logic [15:0] PRESET_T1 = 16'd4000;
   localparam logic [15:0] PRESET_T2 = 16'd3000;
   localparam logic [15:0] PRESET_T3 = 16'd2000;

   typedef struct packed {
      logic [2:0]  num_lit;
      logic [15:0] preset;
   } tier_t;

   // Higher scores light more moles and shorten the round timeout.
   function automatic tier_t tier_of(input logic [31:0] score);
      tier_t t;
      if (score < TIER_LIM0) begin
         t.num_lit = NUM_LIT_T0;
         t.preset  = PRESET_T0;
      end else if (score < TIER_LIM1) begin
         t.num_lit = NUM_LIT_T1;
         t.preset  = PRESET_T1;
      end else if (score < TIER_LIM2) begin
         t.num_lit = NUM_LIT_T2;
         t.preset  = PRESET_T2;
      end else begin
         t.num_lit = NUM_LIT_T3;
         t.preset  = PRESET_T3;
      end
      return t;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: one-cycle tick every CLK_PER_TICK clocks, restartable
// via clr so a new session starts on a tick boundary.
module tick_gen #(
   parameter int unsigned CLK_PER_TICK = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_TICK - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == CNT_MAX)) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == CNT_MAX) && !clr;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer: IDLE -> CLEAR -> ARM countdown -> timed PLAY -> END hold,
// plus round restart strobes, difficulty tier and the session high score.
module game_session_ctrl
   import game_pkg::*;
#(
   parameter int unsigned CLK_PER_TICK   = 1000,
   parameter int unsigned ARM_TICKS      = 3000,
   parameter int unsigned GAME_TICKS     = 60000,
   parameter int unsigned END_HOLD_TICKS = 5000,
   parameter int unsigned SCORE_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               abort_btn,
   input  logic               hit,
   input  logic               round_expired,
   input  logic [SCORE_W-1:0] score,
   output logic [2:0]         state,
   output logic               game_clr,
   output logic               play_en,
   output logic               round_reset,
   output logic [2:0]         num_lit,
   output logic [15:0]        round_preset,
   output logic [15:0]        time_left,
   output logic [1:0]         arm_digit,
   output logic [SCORE_W-1:0] hi_score,
   output logic               new_hi
);

   localparam logic [15:0] ARM_LAST       = 16'(ARM_TICKS - 1);
   localparam logic [15:0] END_LAST       = 16'(END_HOLD_TICKS - 1);
   localparam logic [15:0] GAME_T         = 16'(GAME_TICKS);
   localparam logic [15:0] ARM_THIRD      = 16'(ARM_TICKS / 3);
   localparam logic [15:0] ARM_TWO_THIRDS = 16'(2 * (ARM_TICKS / 3));

   state_e             state_q, state_d;
   logic               start_q;
   logic               tick;
   logic               start_rise;
   logic               play_hit;
   tier_t              tier;
   logic [15:0]        phase_q, phase_d;
   logic [15:0]        time_left_q, time_left_d;
   logic [SCORE_W-1:0] hi_q, hi_d;
   logic               new_hi_q, new_hi_d;
   logic               game_clr_q, game_clr_d;
   logic               play_en_q, play_en_d;
   logic               round_reset_q, round_reset_d;
   logic               refresh_q, refresh_d;
   logic [2:0]         num_lit_q, num_lit_d;
   logic [15:0]        preset_q, preset_d;
   logic [1:0]         arm_digit_q, arm_digit_d;

   tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == ST_CLEAR),
      .tick (tick)
   );

   always_comb begin
      start_rise    = start_btn & ~start_q;
      state_d       = state_q;
      phase_d       = phase_q;
      time_left_d   = time_left_q;
      hi_d          = hi_q;
      new_hi_d      = new_hi_q;
      round_reset_d = 1'b0;
      play_hit      = 1'b0;
      case (state_q)
         ST_IDLE: if (start_rise) state_d = ST_CLEAR;
         ST_CLEAR: begin
            time_left_d = GAME_T;
            new_hi_d    = 1'b0;
            phase_d     = '0;
            state_d     = ST_ARM;
         end
         ST_ARM: begin
            if (abort_btn) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (phase_q == ARM_LAST) begin
                  state_d       = ST_PLAY;
                  phase_d       = '0;
                  round_reset_d = 1'b1;
               end else begin
                  phase_d = phase_q + 16'd1;
               end
            end
         end
         ST_PLAY: begin
            // Abort wins over both game-over and a simultaneous hit.
            if (abort_btn) begin
               state_d = ST_IDLE;
            end else begin
               round_reset_d = hit | round_expired;
               play_hit      = hit;
               if (time_left_q == 16'd0) begin
                  state_d = ST_END;
                  phase_d = '0;
                  if (score > hi_q) begin
                     hi_d     = score;
                     new_hi_d = 1'b1;
                  end
               end else if (tick) begin
                  time_left_d = time_left_q - 16'd1;
               end
            end
         end
         ST_END: begin
            if (tick) begin
               if (phase_q == END_LAST) state_d = ST_IDLE;
               else                     phase_d = phase_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      game_clr_d  = (state_d == ST_CLEAR);
      play_en_d   = (state_d == ST_PLAY);
      arm_digit_d = 2'd0;
      if (state_d == ST_ARM) begin
         if (phase_d < ARM_THIRD)           arm_digit_d = 2'd3;
         else if (phase_d < ARM_TWO_THIRDS) arm_digit_d = 2'd2;
         else                               arm_digit_d = 2'd1;
      end

      // Tier is sampled one cycle late so the pattern FSM's score has settled.
      refresh_d = game_clr_q | play_hit;
      tier      = tier_of(32'(score));
      num_lit_d = refresh_q ? tier.num_lit : num_lit_q;
      preset_d  = refresh_q ? tier.preset  : preset_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         start_q       <= 1'b0;
         phase_q       <= '0;
         time_left_q   <= '0;
         hi_q          <= '0;
         new_hi_q      <= 1'b0;
         game_clr_q    <= 1'b0;
         play_en_q     <= 1'b0;
         round_reset_q <= 1'b0;
         refresh_q     <= 1'b0;
         num_lit_q     <= NUM_LIT_T0;
         preset_q      <= PRESET_T0;
         arm_digit_q   <= 2'd0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_btn;
         phase_q       <= phase_d;
         time_left_q   <= time_left_d;
         hi_q          <= hi_d;
         new_hi_q      <= new_hi_d;
         game_clr_q    <= game_clr_d;
         play_en_q     <= play_en_d;
         round_reset_q <= round_reset_d;
         refresh_q     <= refresh_d;
         num_lit_q     <= num_lit_d;
         preset_q      <= preset_d;
         arm_digit_q   <= arm_digit_d;
      end
   end

   assign state        = state_q;
   assign game_clr     = game_clr_q;
   assign play_en      = play_en_q;
   assign round_reset  = round_reset_q;
   assign num_lit      = num_lit_q;
   assign round_preset = preset_q;
   assign time_left    = time_left_q;
   assign arm_digit    = arm_digit_q;
   assign hi_score     = hi_q;
   assign new_hi       = new_hi_q;

endmodule
